// File: rtl/uart_rx_bit_sampler_pkg.sv
// Shared UART Rx definitions: one-hot state codes, parity mode codes and the
// bitwise 2-of-3 vote used by the triplicated build (UART_RX_SAMPLER_TMR_EN).
package uart_rx_bit_sampler_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int TMR_W = 8;

    function automatic logic [TMR_W-1:0] tmr_vote(input logic [TMR_W-1:0] a,
                                                  input logic [TMR_W-1:0] b,
                                                  input logic [TMR_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Three-sample majority voter: keeps the two previous samples and votes them
// together with the sample being taken, so the result is ready on the third strobe.
module uart_rx_majority3 (
    input  logic clk,
    input  logic rst,
    input  logic shift_i,
    input  logic sample_i,
    output logic vote_o
);

    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b00;
        end else if (shift_i) begin
            hist_q <= {hist_q[0], sample_i};
        end
    end

    assign vote_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sample_i) | (hist_q[0] & sample_i);

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART Rx front end: line synchroniser, start qualification, 3-sample voting,
// LSB-first assembly, parity/stop check. UART_RX_SAMPLER_TMR_EN triplicates state/counters.
module uart_rx_bit_sampler
    import uart_rx_bit_sampler_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_i,
    input  logic                 AcqSig_i,
    input  logic [1:0]           Parity_Mode_i,
    output logic                 Rx_Synch_o,
    output logic                 Bit_Synch_o,
    output logic                 Bit_o,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 Byte_Valid_o,
    output logic                 Parity_Err_o,
    output logic                 Frame_Err_o,
    output logic [4:0]           dbg_state_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int H  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP_FIRST = CW'(H - 1);
    localparam logic [CW-1:0] SMP_LAST  = CW'(H + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic sync1_q, sync2_q, hist_q;
    logic fall_edge, in_frame, sample_en, vote_en, bit_end, vote, parity_en;

    rx_state_e state_r, state_d;
    logic [CW-1:0] cnt_r, cnt_d;
    logic [BW-1:0] bit_cnt_r, bit_cnt_d;

    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic [1:0] par_mode_q, par_mode_d;
    logic par_err_q, par_err_d;
    logic rx_synch_q, rx_synch_d, bit_synch_q, bit_synch_d, bit_q, bit_d;
    logic byte_valid_q, byte_valid_d, perr_q, perr_d, ferr_q, ferr_d;

    // Synchroniser and history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= Rx_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign fall_edge = hist_q & ~sync2_q;
    assign in_frame  = (state_r != ST_IDLE);
    assign sample_en = in_frame & AcqSig_i & (cnt_r >= SMP_FIRST) & (cnt_r <= SMP_LAST);
    assign vote_en   = in_frame & AcqSig_i & (cnt_r == SMP_LAST);
    assign bit_end   = in_frame & AcqSig_i & (cnt_r == CNT_LAST);
    assign parity_en = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);

    uart_rx_majority3 u_vote (
        .clk      (clk),
        .rst      (rst),
        .shift_i  (sample_en),
        .sample_i (sync2_q),
        .vote_o   (vote)
    );

    always_comb begin
        state_d      = state_r;
        cnt_d        = cnt_r;
        bit_cnt_d    = bit_cnt_r;
        shift_d      = shift_q;
        data_d       = data_q;
        par_mode_d   = par_mode_q;
        par_err_d    = par_err_q;
        rx_synch_d   = rx_synch_q;
        bit_synch_d  = 1'b0;
        bit_d        = bit_q;
        byte_valid_d = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        if (in_frame && AcqSig_i) begin
            cnt_d = (cnt_r == CNT_LAST) ? '0 : cnt_r + CW'(1);
        end
        case (state_r)
            ST_IDLE: if (fall_edge) begin
                state_d    = ST_START;
                cnt_d      = '0;
                bit_cnt_d  = '0;
                rx_synch_d = 1'b1;
                par_mode_d = Parity_Mode_i;
                par_err_d  = 1'b0;
            end
            ST_START: if (vote_en) begin
                if (vote) begin
                    state_d    = ST_IDLE;
                    rx_synch_d = 1'b0;
                end else begin
                    bit_synch_d = 1'b1;
                    bit_d       = 1'b0;
                end
            end else if (bit_end) begin
                state_d = ST_DATA;
            end
            ST_DATA: if (vote_en) begin
                bit_synch_d = 1'b1;
                bit_d       = vote;
                shift_d     = {vote, shift_q[DATA_BITS-1:1]};
            end else if (bit_end) begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = parity_en ? ST_PARITY : ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_r + BW'(1);
                end
            end
            ST_PARITY: if (vote_en) begin
                bit_synch_d = 1'b1;
                bit_d       = vote;
                par_err_d   = vote ^ (^shift_q) ^ (par_mode_q == PAR_ODD);
            end else if (bit_end) begin
                state_d = ST_STOP;
            end
            // Frame closes at the stop-bit vote so a back-to-back start edge is caught.
            ST_STOP: if (vote_en) begin
                bit_synch_d  = 1'b1;
                bit_d        = vote;
                data_d       = shift_q;
                byte_valid_d = 1'b1;
                perr_d       = par_err_q;
                ferr_d       = ~vote;
                rx_synch_d   = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                rx_synch_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            data_q       <= '0;
            par_mode_q   <= PAR_NONE;
            par_err_q    <= 1'b0;
            rx_synch_q   <= 1'b0;
            bit_synch_q  <= 1'b0;
            bit_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_mode_q   <= par_mode_d;
            par_err_q    <= par_err_d;
            rx_synch_q   <= rx_synch_d;
            bit_synch_q  <= bit_synch_d;
            bit_q        <= bit_d;
            byte_valid_q <= byte_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

`ifdef UART_RX_SAMPLER_TMR_EN
    logic [4:0]    state_q   [3];
    logic [CW-1:0] cnt_q     [3];
    logic [BW-1:0] bit_cnt_q [3];
    logic [TMR_W-1:0] state_v, cnt_v, bit_cnt_v;

    assign state_v   = tmr_vote(TMR_W'(state_q[0]), TMR_W'(state_q[1]), TMR_W'(state_q[2]));
    assign cnt_v     = tmr_vote(TMR_W'(cnt_q[0]), TMR_W'(cnt_q[1]), TMR_W'(cnt_q[2]));
    assign bit_cnt_v = tmr_vote(TMR_W'(bit_cnt_q[0]), TMR_W'(bit_cnt_q[1]), TMR_W'(bit_cnt_q[2]));
    assign state_r   = rx_state_e'(state_v[4:0]);
    assign cnt_r     = cnt_v[CW-1:0];
    assign bit_cnt_r = bit_cnt_v[BW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= ST_IDLE;
                cnt_q[i]     <= '0;
                bit_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= state_d;
                cnt_q[i]     <= cnt_d;
                bit_cnt_q[i] <= bit_cnt_d;
            end
        end
    end
`else
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_cnt_q;

    assign state_r   = state_q;
    assign cnt_r     = cnt_q;
    assign bit_cnt_r = bit_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
`endif

    assign Rx_Synch_o   = rx_synch_q;
    assign Bit_Synch_o  = bit_synch_q;
    assign Bit_o        = bit_q;
    assign Data_o       = data_q;
    assign Byte_Valid_o = byte_valid_q;
    assign Parity_Err_o = perr_q;
    assign Frame_Err_o  = ferr_q;
    assign dbg_state_o  = state_r;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: OVERSAMPLE=16, DATA_BITS=8, AcqSig every 4 clk,
// so one bit lasts 64 clk. Voted bits are scored against an expected-bit queue.
module tb_uart_rx_bit_sampler;

    logic       clk, rst, Rx_i, AcqSig_i;
    logic [1:0] Parity_Mode_i;
    logic       Rx_Synch_o, Bit_Synch_o, Bit_o, Byte_Valid_o, Parity_Err_o, Frame_Err_o;
    logic [7:0] Data_o;
    logic [4:0] dbg_state_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int bs_cnt = 0, bv_cnt = 0, rs_cnt = 0;
    int bs0, bv0, rs0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0, cap_ferr = 1'b0;
    logic [0:0] exp_q[$];
    logic [0:0] exp_bit;

    uart_rx_bit_sampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .Rx_i          (Rx_i),
        .AcqSig_i      (AcqSig_i),
        .Parity_Mode_i (Parity_Mode_i),
        .Rx_Synch_o    (Rx_Synch_o),
        .Bit_Synch_o   (Bit_Synch_o),
        .Bit_o         (Bit_o),
        .Data_o        (Data_o),
        .Byte_Valid_o  (Byte_Valid_o),
        .Parity_Err_o  (Parity_Err_o),
        .Frame_Err_o   (Frame_Err_o),
        .dbg_state_o   (dbg_state_o)
    );

    // clock / reset / oversample strobe
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        AcqSig_i = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            AcqSig_i = 1'b1;
            @(negedge clk);
            AcqSig_i = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every Bit_Synch pulse must match the next expected bit
    always @(negedge clk) begin
        if (rst) begin
            if (Rx_Synch_o) rs_cnt++;
            if (Byte_Valid_o) begin
                bv_cnt++;
                cap_data = Data_o;
                cap_perr = Parity_Err_o;
                cap_ferr = Frame_Err_o;
            end
            if (Bit_Synch_o) begin
                bs_cnt++;
                chk("bit_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_bit = exp_q.pop_front();
                    chk("bit_value", 32'(Bit_o), 32'(exp_bit));
                end
            end
        end
    end

    // driver tasks
    task automatic send_bit(input logic v, input bit glitch);
        exp_q.push_back(v);
        Rx_i = v;
        if (glitch) begin
            repeat (33) @(negedge clk);
            Rx_i = ~v;
            repeat (4) @(negedge clk);
            Rx_i = v;
            repeat (27) @(negedge clk);
        end else begin
            repeat (64) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                              input logic stop_bit, input bit glitch, input logic [1:0] mode_after);
        send_bit(1'b0, 1'b0);
        Parity_Mode_i = mode_after;
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        if (has_par) send_bit(par_bit, 1'b0);
        send_bit(stop_bit, 1'b0);
        Rx_i = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic snap();
        bs0 = bs_cnt;
        bv0 = bv_cnt;
        rs0 = rs_cnt;
    endtask

    initial begin
        rst = 1'b0;
        Rx_i = 1'b1;
        Parity_Mode_i = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_rx_synch", 32'(Rx_Synch_o), 32'd0);
        chk("rst_bit_synch", 32'(Bit_Synch_o), 32'd0);
        chk("rst_bit", 32'(Bit_o), 32'd0);
        chk("rst_data", 32'(Data_o), 32'h00);
        chk("rst_byte_valid", 32'(Byte_Valid_o), 32'd0);
        chk("rst_perr", 32'(Parity_Err_o), 32'd0);
        chk("rst_ferr", 32'(Frame_Err_o), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'h01);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: even parity 0x55, parity bit 0, stop 1
        Parity_Mode_i = 2'b10;
        snap();
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
        chk("t1_data", 32'(cap_data), 32'h55);
        chk("t1_byte_valid", 32'(bv_cnt - bv0), 32'd1);
        chk("t1_perr", 32'(cap_perr), 32'd0);
        chk("t1_ferr", 32'(cap_ferr), 32'd0);
        chk("t1_bit_synch", 32'(bs_cnt - bs0), 32'd11);
        chk("t1_rx_synch_len", 32'((rs_cnt - rs0) > 600), 32'd1);
        chk("t1_rx_synch_end", 32'(Rx_Synch_o), 32'd0);
        chk("t1_state_idle", 32'(dbg_state_o), 32'h01);

        // 2: false start, line low for 3 oversample periods
        snap();
        Rx_i = 1'b0;
        repeat (12) @(negedge clk);
        Rx_i = 1'b1;
        repeat (60) @(negedge clk);
        chk("t2_rx_synch_seen", 32'((rs_cnt - rs0) > 0), 32'd1);
        chk("t2_no_bit_synch", 32'(bs_cnt - bs0), 32'd0);
        chk("t2_no_byte_valid", 32'(bv_cnt - bv0), 32'd0);
        chk("t2_rx_synch_end", 32'(Rx_Synch_o), 32'd0);
        chk("t2_state_idle", 32'(dbg_state_o), 32'h01);

        // 3: odd parity 0xA3 with wrong parity bit; mode change mid-frame ignored
        Parity_Mode_i = 2'b01;
        snap();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("t3_data", 32'(cap_data), 32'hA3);
        chk("t3_byte_valid", 32'(bv_cnt - bv0), 32'd1);
        chk("t3_perr", 32'(cap_perr), 32'd1);
        chk("t3_ferr", 32'(cap_ferr), 32'd0);
        chk("t3_bit_synch", 32'(bs_cnt - bs0), 32'd11);

        // 4: no parity 0x0F with stop bit 0
        Parity_Mode_i = 2'b00;
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("t4_data", 32'(cap_data), 32'h0F);
        chk("t4_byte_valid", 32'(bv_cnt - bv0), 32'd1);
        chk("t4_ferr", 32'(cap_ferr), 32'd1);
        chk("t4_perr", 32'(cap_perr), 32'd0);
        chk("t4_bit_synch", 32'(bs_cnt - bs0), 32'd10);

        // 5: glitch on the middle sample of every data bit, mode 11 = no parity
        Parity_Mode_i = 2'b11;
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        chk("t5_data", 32'(cap_data), 32'h3C);
        chk("t5_byte_valid", 32'(bv_cnt - bv0), 32'd1);
        chk("t5_perr", 32'(cap_perr), 32'd0);
        chk("t5_ferr", 32'(cap_ferr), 32'd0);
        chk("t5_bit_synch", 32'(bs_cnt - bs0), 32'd10);

        // 6: reset mid-DATA, then a clean 0x81
        Parity_Mode_i = 2'b00;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("t6_mid_rx_synch", 32'(Rx_Synch_o), 32'd1);
        chk("t6_mid_state_data", 32'(dbg_state_o), 32'h04);
        rst = 1'b0;
        #1;
        chk("t6_rst_rx_synch", 32'(Rx_Synch_o), 32'd0);
        chk("t6_rst_data", 32'(Data_o), 32'h00);
        chk("t6_rst_bit_synch", 32'(Bit_Synch_o), 32'd0);
        chk("t6_rst_byte_valid", 32'(Byte_Valid_o), 32'd0);
        chk("t6_rst_state", 32'(dbg_state_o), 32'h01);
        exp_q.delete();
        Rx_i = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("t6_data", 32'(cap_data), 32'h81);
        chk("t6_byte_valid", 32'(bv_cnt - bv0), 32'd1);
        chk("t6_perr", 32'(cap_perr), 32'd0);
        chk("t6_ferr", 32'(cap_ferr), 32'd0);
        chk("t6_bit_synch", 32'(bs_cnt - bs0), 32'd10);
        chk("end_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
